// File: rtl/fourbee_ctrl.sv
// fourbee_ctrl: multi-cycle fetch/decode/execute FSM for the fourbee 4-bit CPU.
// Define FOURBEE_SINGLE_STEP_EN to add the step input and a PAUSE state after each retire.
module fourbee_ctrl #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
`ifdef FOURBEE_SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr,
    output logic [3:0]         alu_op,
    output logic [1:0]         rx_sel,
    output logic [1:0]         ry_sel,
    output logic [3:0]         mem_addr,
    output logic               mem_req,
    input  logic               mem_ack,
    input  logic               alu_z,
    input  logic               alu_n,
    output logic               reg_we,
    output logic               flag_z,
    output logic               flag_n,
    output logic               halted
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_MEM    = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;
    localparam logic [2:0] S_PAUSE  = 3'd5;
`ifdef FOURBEE_SINGLE_STEP_EN
    localparam logic [2:0] S_RETIRE = S_PAUSE;
`else
    localparam logic [2:0] S_RETIRE = S_FETCH;
`endif
    logic [2:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               fz_q, fz_d, fn_q, fn_d;
    logic               retire, alu_x, cond, take;
    assign alu_x  = (state_q == S_EXEC && ir_q[11:10] == 2'b00) || (state_q == S_MEM && mem_ack);
    assign retire = state_q == S_EXEC || (state_q == S_MEM && mem_ack);
    assign cond   = ir_q[9:8] == 2'b00 ? 1'b1 : ir_q[9:8] == 2'b01 ? fz_q :
                    ir_q[9:8] == 2'b10 ? fn_q : !fz_q;
    assign take   = ir_q[11:10] == 2'b10 && cond;
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = retire ? (take ? PC_W'(ir_q[7:0]) : pc_q + 1'b1) : pc_q;
        fz_d    = alu_x ? alu_z : fz_q;
        fn_d    = alu_x ? alu_n : fn_q;
        case (state_q)
            S_FETCH:  state_d = run ? S_DECODE : S_FETCH;
            S_DECODE: begin
                ir_d    = instr;
                state_d = instr[11:10] == 2'b01 ? S_MEM : instr[11:10] == 2'b11 ? S_HALT : S_EXEC;
            end
            S_MEM:    state_d = mem_ack ? S_RETIRE : S_MEM;
            S_EXEC:   state_d = S_RETIRE;
            S_HALT:   state_d = S_HALT;
`ifdef FOURBEE_SINGLE_STEP_EN
            S_PAUSE:  state_d = step ? S_FETCH : S_PAUSE;
`endif
            default:  state_d = S_FETCH;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            fz_q    <= 1'b0;
            fn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            fz_q    <= fz_d;
            fn_q    <= fn_d;
        end
    end
    // Strobes decode straight from state so async reset clears them the same cycle.
    assign pc       = pc_q;
    assign alu_op   = ir_q[9:6];
    assign rx_sel   = ir_q[5:4];
    assign ry_sel   = ir_q[3:2];
    assign mem_addr = ir_q[3:0];
    assign mem_req  = state_q == S_MEM;
    assign reg_we   = alu_x;
    assign flag_z   = fz_q;
    assign flag_n   = fn_q;
    assign halted   = state_q == S_HALT;
endmodule

// File: tb/tb_fourbee_ctrl.sv
// tb_fourbee_ctrl: directed-vector bench for fourbee_ctrl (default build) with a synchronous ROM model.
module tb_fourbee_ctrl;
    logic        clk = 1'b0;
    logic        rst, run, mem_ack, alu_z, alu_n;
    logic [7:0]  pc;
    logic [11:0] instr;
    logic [3:0]  alu_op, mem_addr;
    logic [1:0]  rx_sel, ry_sel;
    logic        mem_req, reg_we, flag_z, flag_n, halted;
    logic [11:0] rom [256];
    int          total = 0;
    int          bad = 0;
    always #5 clk = ~clk;
    always @(posedge clk) instr <= rom[pc];
    fourbee_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .pc(pc), .instr(instr),
        .alu_op(alu_op), .rx_sel(rx_sel), .ry_sel(ry_sel), .mem_addr(mem_addr),
        .mem_req(mem_req), .mem_ack(mem_ack), .alu_z(alu_z), .alu_n(alu_n),
        .reg_we(reg_we), .flag_z(flag_z), .flag_n(flag_n), .halted(halted)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask
    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 12'h000;
        rom[8'h00] = 12'h0D8;
        rom[8'h01] = 12'h427;
        rom[8'h02] = 12'h940;
        rom[8'h40] = 12'h040;
        rom[8'h41] = 12'h910;
        rom[8'h42] = 12'h8FF;
        rom[8'hFF] = 12'h0D8;
        rst = 1'b1; run = 1'b0; mem_ack = 1'b0; alu_z = 1'b1; alu_n = 1'b0;
        cyc(2);
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_we", reg_we, 0);
        rst = 1'b0; run = 1'b1;
        cyc(5);
        chk("pre_req", mem_req, 1);
        chk("pre_flag_z", flag_z, 1);
        rst = 1'b1;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_pc", pc, 0);
        chk("arst_flag_z", flag_z, 0);
        chk("arst_alu_op", alu_op, 0);
        cyc(1);
        rst = 1'b0; run = 1'b0; mem_ack = 1'b1;
        #1 chk("late_ack_we", reg_we, 0);
        cyc(1);
        chk("late_ack_pc", pc, 0);
        chk("late_ack_req", mem_req, 0);
        mem_ack = 1'b0; run = 1'b1;
        cyc(1);
        chk("dec_we", reg_we, 0);
        cyc(1);
        chk("exec_we", reg_we, 1);
        chk("exec_alu_op", alu_op, 4'b0011);
        chk("exec_rx", rx_sel, 2'b01);
        chk("exec_ry", ry_sel, 2'b10);
        cyc(1);
        chk("rr_we_off", reg_we, 0);
        chk("rr_pc", pc, 1);
        chk("rr_flag_z", flag_z, 1);
        chk("rr_flag_n", flag_n, 0);
        rom[8'h00] = 12'hC00;
        alu_n = 1'b1;
        cyc(2);
        for (int i = 0; i < 3; i++) begin
            chk("mw_req", mem_req, 1);
            chk("mw_addr", mem_addr, 4'b0111);
            chk("mw_we", reg_we, 0);
            cyc(1);
        end
        mem_ack = 1'b1;
        #1;
        chk("ack_req", mem_req, 1);
        chk("ack_we", reg_we, 1);
        cyc(1);
        mem_ack = 1'b0; alu_z = 1'b0; alu_n = 1'b0;
        #1;
        chk("rm_req_off", mem_req, 0);
        chk("rm_pc", pc, 2);
        chk("rm_flag_n", flag_n, 1);
        cyc(2);
        chk("br_we", reg_we, 0);
        cyc(1);
        chk("br_taken_pc", pc, 8'h40);
        chk("br_flag_z", flag_z, 1);
        chk("br_flag_n", flag_n, 1);
        cyc(3);
        chk("alu40_pc", pc, 8'h41);
        chk("alu40_flag_z", flag_z, 0);
        alu_z = 1'b1;
        cyc(3);
        chk("br_nt_pc", pc, 8'h42);
        chk("br_nt_flag_z", flag_z, 0);
        cyc(3);
        chk("br_always_pc", pc, 8'hFF);
        cyc(3);
        chk("wrap_pc", pc, 8'h00);
        chk("wrap_flag_z", flag_z, 1);
        cyc(2);
        chk("halted", halted, 1);
        for (int i = 0; i < 20; i++) begin
            run = i[0];
            mem_ack = i[1];
            cyc(1);
            chk("halt_pc", pc, 0);
            chk("halt_hold", halted, 1);
            chk("halt_we", reg_we | mem_req, 0);
        end
        rst = 1'b1;
        #1 chk("halt_rst", halted, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fourbee_ctrl.md
Name: fourbee_ctrl

Overview:
Multi-cycle control FSM that sequences the 4-bit ALU datapath of the fourbee CPU. It fetches 12-bit instructions from a synchronous program ROM and decodes them. It drives ALU opcode, register-select and write-enable lines, and handshakes with data memory for memory-operand ALU ops. It latches the ALU z/n flags and executes conditional branches and halt. It sits between the program ROM, the register file, the ALU and the data-memory port.

Parameters:
PC_W, 8, program-counter width; ROM depth 2^PC_W
INSTR_W, 12, instruction width; fixed encoding below, values other than 12 unsupported

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  allow leaving FETCH; sampled only in FETCH
pc  output  PC_W  program ROM address
instr  input  INSTR_W  ROM data, valid one cycle after pc presented
alu_op  output  4  ALU opcode, = ir[9:6]
rx_sel  output  2  destination/first-operand register select, = ir[5:4]
ry_sel  output  2  second-operand register select, = ir[3:2]
mem_addr  output  4  data-memory address, = ir[3:0]
mem_req  output  1  data-memory read request
mem_ack  input  1  data-memory read complete; mem value valid to ALU this cycle
alu_z  input  1  ALU zero flag, combinational from current op
alu_n  input  1  ALU negative flag
reg_we  output  1  register-file write strobe, writes ALU out to rx_sel
flag_z  output  1  latched zero flag
flag_n  output  1  latched negative flag
halted  output  1  high in HALT state

Behaviour:
- Encoding, ir[11:10]:
  - 00: ALU reg-reg.
  - 01: ALU reg-mem; the mem operand is read at mem_addr.
  - 10: BRANCH. Condition ir[9:8]: 00 always, 01 flag_z, 10 flag_n, 11 !flag_z. Target ir[7:0], truncated/zero-extended to PC_W.
  - 11: HALT.
- States: FETCH, DECODE, MEM_WAIT, EXEC, HALT.
- FETCH: pc stable. If run=1, go to DECODE next cycle; otherwise stay.
- DECODE: ir <= instr.
  - Class 01 goes to MEM_WAIT.
  - Class 11 goes to HALT.
  - All other classes go to EXEC.
- MEM_WAIT:
  - mem_req=1 every cycle until mem_ack=1.
  - The mem_ack cycle is also the execute cycle: reg_we=1 and flags latched. It then behaves as EXEC (go to FETCH, pc+1).
  - mem_ack outside MEM_WAIT is ignored.
- EXEC, class 00: reg_we=1 for exactly one cycle. flag_z<=alu_z, flag_n<=alu_n. pc<=pc+1. Go to FETCH.
- EXEC, class 10: reg_we=0, flags unchanged. pc<=target if the condition holds, else pc+1. Go to FETCH.
- HALT: all strobes 0, pc frozen, halted=1. Left only via rst.
- Latency at run=1: reg-reg ALU op and branch take 3 cycles. Reg-mem op takes 3+k cycles, where k is the number of cycles mem_ack stays low.
- alu_op, rx_sel, ry_sel and mem_addr are driven from ir at all times. They are registered and glitch-free.
- pc wraps modulo 2^PC_W; 0xFF+1 -> 0x00 at PC_W=8.
- run dropping mid-instruction: the current instruction completes. The FSM then waits in FETCH.
- rst, asynchronous at any time including MEM_WAIT:
  - State <= FETCH.
  - pc, ir, flag_z, flag_n, reg_we, mem_req, halted all <= 0.
  - An outstanding memory request is abandoned; a late mem_ack is ignored.
- Flags change only on ALU-class execute cycles.

Optional Feature:
FOURBEE_SINGLE_STEP_EN.
- Defined: adds input port step (1 bit) and state PAUSE.
  - After each retired instruction (EXEC or MEM_WAIT completion), the FSM goes to PAUSE instead of FETCH.
  - PAUSE to FETCH on the first cycle step=1. Holding step high retires at most one instruction per PAUSE visit.
  - A branch or HALT retiring also passes through PAUSE, except HALT goes straight to HALT.
- Undefined: no step port, no PAUSE state; free-running as above.

Test Plan:
- Reset: assert rst mid-MEM_WAIT with mem_req=1 -> the same cycle, all outputs 0 and state FETCH. After release with run=1, pc=0 is fetched.
- ALU reg-reg: ROM[0]=12'b00_0011_01_10_00, alu_z=1, alu_n=0 -> alu_op=0011, rx_sel=01, ry_sel=10. reg_we is high for exactly one cycle, 3 cycles after leaving reset. flag_z=1, flag_n=0, pc=1.
- Reg-mem wait: ROM[1]=12'b01_0000_10_0111 with mem_ack low for 3 cycles -> mem_req high for 4 cycles and mem_addr=0111. reg_we is pulsed only in the ack cycle; pc=2 afterwards.
- Branch: with flag_z=1, BRANCH cond 01 target 0x40 -> pc=0x40. With flag_z=0, pc+1. reg_we stays 0 and flags are unchanged.
- Wrap/halt: pc=0xFF with an ALU op -> next pc=0x00. ROM[0]=HALT -> halted=1, pc frozen for 20 cycles, and run has no effect.
- Single step (macro defined): step held low -> pc stays constant in PAUSE. One step pulse -> exactly one instruction retires.
